traffic_phase_scheduler: RTL and testbench
==========================================

# traffic_phase_scheduler

Timed, demand-driven phase scheduler for the two-road intersection: sequences road A and road B through green, yellow and all-red phases with programmable minimum and maximum green times, and optionally inserts a pedestrian walk phase between them. It sits above the per-road lamp drivers, replacing fixed cycle-count sequencing with parameterised timers. Lamp outputs are Moore-decoded from the state register, so both roads can never be non-red at once.

## Interface
- GREEN_MIN, default 6: minimum green cycles per road (≥1).
- GREEN_MAX, default 20: green cycles after which a road yields even if its own sensor is active (≥ GREEN_MIN).
- YELLOW_LEN, default 2: yellow cycles (≥1).
- ALL_RED_LEN, default 1: all-red clearance cycles (≥1).
- WALK_LEN, default 4: pedestrian walk cycles (≥1).
- CNT_W, default 8: phase counter width; must hold max(GREEN_MAX, WALK_LEN) − 1.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; asynchronous, active-high.
- sensor_A  in  1  1 = cars waiting or present on road A.
- sensor_B  in  1  1 = cars waiting or present on road B.
- ped_req  in  1  pedestrian button; sampled each cycle, any 1 sets the request latch.
- light_A  out  3  one-hot {red, yellow, green} for road A.
- light_B  out  3  one-hot {red, yellow, green} for road B.
- walk  out  1  pedestrian walk lamp.
- phase  out  3  current state encoding, for debug and coverage.
- ped_pending  out  1  pedestrian request latch.

## Operation
- States (phase encoding): A_GREEN=0, A_YELLOW=1, ALL_RED_AB=2, B_GREEN=3, B_YELLOW=4, ALL_RED_BA=5, PED_WALK=6.
- cnt: cycles spent in the current state; 0 on the first cycle after entry; saturates at GREEN_MAX−1 in green states.
- Green exit (A_GREEN shown, B symmetric): leave when cnt ≥ GREEN_MIN−1 AND (sensor_B OR ped_pending) AND (!sensor_A OR cnt ≥ GREEN_MAX−1). With no opposing demand, green holds indefinitely.
- X_YELLOW → following ALL_RED when cnt = YELLOW_LEN−1.
- ALL_RED_AB at cnt = ALL_RED_LEN−1: if ped_pending → PED_WALK with ret_dir=B; else → B_GREEN. ALL_RED_BA is symmetric, with ret_dir=A → A_GREEN.
- PED_WALK at cnt = WALK_LEN−1 → green of ret_dir. Clearance is already done because all roads are red during the walk.
- ped_pending: set by ped_req = 1; cleared on the clock edge that enters PED_WALK. A ped_req in that same cycle is absorbed (clear wins).
- Output decode:
  - A_GREEN: light_A=001, light_B=100.
  - A_YELLOW: light_A=010, light_B=100.
  - B_GREEN: light_A=100, light_B=001.
  - B_YELLOW: light_A=100, light_B=010.
  - ALL_RED_AB, ALL_RED_BA, PED_WALK: both 100.
  - walk=1 only in PED_WALK.
- Unreachable state encoding (7): outputs are all-red and the next state is ALL_RED_BA.

## Timing
- Reset values: state A_GREEN, cnt 0, ret_dir A, ped_pending 0, light_A=001, light_B=100, walk 0, phase 0.
- Reset asserted mid-phase forces the reset values immediately, without waiting for a clock edge.
- A transition decided in cycle n shows on the lamps in cycle n+1. All outputs are registered or decoded from registered state, with no input-to-output combinational path.
- Sensor drop during yellow or all-red has no effect; those phases always run to completion.
- Minimum A-to-B handover: YELLOW_LEN + ALL_RED_LEN cycles of B red after A green ends.

## Configuration
- PED_CROSS_EN defined: ped_req latch and PED_WALK state are present as described above.
- PED_CROSS_EN undefined:
  - ped_req is ignored; ped_pending and walk are tied to 0.
  - PED_WALK is unreachable and is treated as an unreachable state.
  - Green exit demand is the opposing sensor only.

## Test plan
- Reset release with sensor_A=0, sensor_B=1 held: A green for exactly 6 cycles, yellow 2, all-red 1, then B green. phase sequence 0,1,2,3.
- sensor_A=1, sensor_B=1 held: each green lasts exactly 20 cycles (max-out). Full rotation is 2×(20+2+1)=46 cycles, repeating.
- sensor_B=0 forever: A green holds for 200+ cycles with cnt saturated at 19; no yellow appears.
- PED_CROSS_EN, one-cycle ped_req at cycle 2 with no sensors: ped_pending=1 from cycle 3. A leaves green after cycle 5, then yellow 2, all-red 1, walk=1 for 4 cycles with both lights 100, then B green, and ped_pending=0.
- rst pulsed during B_YELLOW: outputs return immediately to light_A=001, light_B=100, phase 0, with no glitch to both-green.
- Assertion over all runs: light_A[2]=0 implies light_B=100, and vice versa. walk=1 implies both lights 100.

Source files
------------

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler
//   Timed, demand-driven phase scheduler for a two-road intersection. It cycles road A and
//   road B through green, yellow and all-red phases with minimum and maximum green times.
//   It can also insert a pedestrian walk phase between the two roads.
//
//   Optional feature macro: PED_CROSS_EN. When it is defined, the pedestrian request latch
//   and the walk phase are built. When it is undefined, ped_req_i is ignored and walk_o and
//   ped_pending_o stay at 0.
//
// Ports
//   clk            clock; all state changes on the rising edge
//   rst            asynchronous, active-high reset
//   sensor_a_i     cars waiting or present on road A
//   sensor_b_i     cars waiting or present on road B
//   ped_req_i      pedestrian button; sampled every cycle
//   light_a_o      one-hot {red, yellow, green} for road A
//   light_b_o      one-hot {red, yellow, green} for road B
//   walk_o         pedestrian walk lamp
//   phase_o        current state encoding, for debug and coverage
//   ped_pending_o  pedestrian request latch
module traffic_phase_scheduler #(
  parameter int unsigned GREEN_MIN   = 6,
  parameter int unsigned GREEN_MAX   = 20,
  parameter int unsigned YELLOW_LEN  = 2,
  parameter int unsigned ALL_RED_LEN = 1,
  parameter int unsigned WALK_LEN    = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sensor_a_i,
  input  logic       sensor_b_i,
  input  logic       ped_req_i,
  output logic [2:0] light_a_o,
  output logic [2:0] light_b_o,
  output logic       walk_o,
  output logic [2:0] phase_o,
  output logic       ped_pending_o
);

  typedef enum logic [2:0] {
    StAGreen   = 3'd0,
    StAYellow  = 3'd1,
    StAllRedAb = 3'd2,
    StBGreen   = 3'd3,
    StBYellow  = 3'd4,
    StAllRedBa = 3'd5,
    StPedWalk  = 3'd6,
    StInvalid  = 3'd7
  } state_e;

  typedef enum logic {DirA = 1'b0, DirB = 1'b1} dir_e;

  localparam logic [CNT_W-1:0] GreenMinM1 = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GreenMaxM1 = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YellowM1   = CNT_W'(YELLOW_LEN - 1);
  localparam logic [CNT_W-1:0] AllRedM1   = CNT_W'(ALL_RED_LEN - 1);
  localparam logic [CNT_W-1:0] WalkM1     = CNT_W'(WALK_LEN - 1);

  localparam logic [2:0] LampRed    = 3'b100;
  localparam logic [2:0] LampYellow = 3'b010;
  localparam logic [2:0] LampGreen  = 3'b001;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  dir_e             ret_q, ret_d;
  logic             ped_q, ped_d;
  logic [2:0]       light_a_d, light_b_d;
  logic             walk_d;
  logic             in_green;

  // Next state, return direction and phase counter.
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    unique case (state_q)
      StAGreen: begin
        if (cnt_q >= GreenMinM1 && (sensor_b_i || ped_q) &&
            (!sensor_a_i || cnt_q >= GreenMaxM1)) begin
          state_d = StAYellow;
        end
      end
      StAYellow:  if (cnt_q == YellowM1) state_d = StAllRedAb;
      StAllRedAb: begin
        if (cnt_q == AllRedM1) begin
          if (ped_q) begin
            state_d = StPedWalk;
            ret_d   = DirB;
          end else begin
            state_d = StBGreen;
          end
        end
      end
      StBGreen: begin
        if (cnt_q >= GreenMinM1 && (sensor_a_i || ped_q) &&
            (!sensor_b_i || cnt_q >= GreenMaxM1)) begin
          state_d = StBYellow;
        end
      end
      StBYellow:  if (cnt_q == YellowM1) state_d = StAllRedBa;
      StAllRedBa: begin
        if (cnt_q == AllRedM1) begin
          if (ped_q) begin
            state_d = StPedWalk;
            ret_d   = DirA;
          end else begin
            state_d = StAGreen;
          end
        end
      end
`ifdef PED_CROSS_EN
      StPedWalk: begin
        if (cnt_q == WalkM1) state_d = (ret_q == DirA) ? StAGreen : StBGreen;
      end
`endif
      // Unreachable encodings go to a safe all-red phase.
      default: state_d = StAllRedBa;
    endcase

    in_green = (state_q == StAGreen) || (state_q == StBGreen);
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (in_green && cnt_q >= GreenMaxM1) begin
      cnt_d = cnt_q;  // saturate while a green holds without opposing demand
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

`ifdef PED_CROSS_EN
  // The edge that enters the walk phase clears the latch, even if ped_req_i is high then.
  always_comb begin
    ped_d = ped_q | ped_req_i;
    if (state_d == StPedWalk && state_q != StPedWalk) ped_d = 1'b0;
  end
`else
  logic unused_ped_req;
  logic unused_ret;
  logic unused_walk_m1;
  assign unused_ped_req = ped_req_i;
  assign unused_ret     = ret_q;
  assign unused_walk_m1 = ^WalkM1;
  assign ped_d          = 1'b0;
`endif

  // Lamp outputs are decoded from the next state, so they land in the same flops' timing
  // as the state itself.
  always_comb begin
    light_a_d = LampRed;
    light_b_d = LampRed;
    walk_d    = 1'b0;
    unique case (state_d)
      StAGreen:  light_a_d = LampGreen;
      StAYellow: light_a_d = LampYellow;
      StBGreen:  light_b_d = LampGreen;
      StBYellow: light_b_d = LampYellow;
`ifdef PED_CROSS_EN
      StPedWalk: walk_d = 1'b1;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StAGreen;
      cnt_q     <= '0;
      ret_q     <= DirA;
      ped_q     <= 1'b0;
      light_a_o <= LampGreen;
      light_b_o <= LampRed;
      walk_o    <= 1'b0;
      phase_o   <= 3'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ret_q     <= ret_d;
      ped_q     <= ped_d;
      light_a_o <= light_a_d;
      light_b_o <= light_b_d;
      walk_o    <= walk_d;
      phase_o   <= state_d;
    end
  end

  assign ped_pending_o = ped_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
module tb_traffic_phase_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sa = 1'b0;
  logic       sb = 1'b0;
  logic       ped = 1'b0;
  logic [2:0] light_a, light_b, phase;
  logic       walk, ped_pending;

  int n_tests = 0;
  int n_fail  = 0;

  traffic_phase_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .sensor_a_i   (sa),
    .sensor_b_i   (sb),
    .ped_req_i    (ped),
    .light_a_o    (light_a),
    .light_b_o    (light_b),
    .walk_o       (walk),
    .phase_o      (phase),
    .ped_pending_o(ped_pending)
  );

  always #5 clk = ~clk;

  // One step of the directed sequence. Inputs are applied first, and then the clock
  // advances adv cycles. Phase and ped_pending are then checked.
  typedef struct {
    bit         rst_first;
    bit         sa;
    bit         sb;
    bit         ped;
    int         adv;
    logic [2:0] phase;
    bit         ped_exp;
  } vec_t;

  localparam int NVec = 19;
  vec_t vecs [NVec];

  function automatic logic [2:0] exp_la(input logic [2:0] p);
    case (p)
      3'd0:    return 3'b001;
      3'd1:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] exp_lb(input logic [2:0] p);
    case (p)
      3'd3:    return 3'b001;
      3'd4:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [2:0] p, input bit pd);
    check({tag, " phase"}, {5'd0, phase}, {5'd0, p});
    check({tag, " light_A"}, {5'd0, light_a}, {5'd0, exp_la(p)});
    check({tag, " light_B"}, {5'd0, light_b}, {5'd0, exp_lb(p)});
    check({tag, " walk"}, {7'd0, walk}, {7'd0, p == 3'd6});
    check({tag, " ped_pending"}, {7'd0, ped_pending}, {7'd0, pd});
  endtask

  // Release happens at a falling edge. The cycle up to the next rising edge is cycle 0.
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Safety invariants, checked every cycle outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      n_tests++;
      if ((!light_a[2] && light_b != 3'b100) || (!light_b[2] && light_a != 3'b100) ||
          (walk && (light_a != 3'b100 || light_b != 3'b100))) begin
        n_fail++;
        $display("FAIL safety: light_A=%b light_B=%b walk=%b", light_a, light_b, walk);
      end
    end
  end

  initial begin
    // Cycle numbers in the comments are counted from reset release.
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 0,   3'd0, 1'b0};  // c0
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 5,   3'd0, 1'b0};  // c5: last min-green cycle
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1,   3'd1, 1'b0};  // c6
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1,   3'd1, 1'b0};  // c7
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1,   3'd2, 1'b0};  // c8
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1,   3'd3, 1'b0};  // c9
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 40,  3'd3, 1'b0};  // c49: B holds
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1,   3'd4, 1'b0};  // c50: already maxed out
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2,   3'd5, 1'b0};  // c52
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1,   3'd0, 1'b0};  // c53: A green entry
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 19,  3'd0, 1'b0};  // c72: 20th green cycle
    vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1,   3'd1, 1'b0};  // c73
    vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 3,   3'd3, 1'b0};  // c76: B green entry
    vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 19,  3'd3, 1'b0};  // c95
    vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 4,   3'd0, 1'b0};  // c99 = c53 + 46
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 200, 3'd0, 1'b0};  // c299: no demand, A holds
    vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 1,   3'd1, 1'b0};  // c300
    vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 3,   3'd3, 1'b0};  // c303: sensor drop ignored
    vecs[18] = '{1'b0, 1'b1, 1'b0, 1'b0, 5,   3'd3, 1'b0};  // c308: min green on B

    for (int i = 0; i < NVec; i++) begin
      sa  = vecs[i].sa;
      sb  = vecs[i].sb;
      ped = vecs[i].ped;
      if (vecs[i].rst_first) do_reset();
      repeat (vecs[i].adv) @(negedge clk);
      check_state($sformatf("vec%0d", i), vecs[i].phase, vecs[i].ped_exp);
    end

    // c309: B_YELLOW. Reset lands between clock edges.
    @(negedge clk);
    check_state("b_yellow", 3'd4, 1'b0);
    #2 rst = 1'b1;
    #1 check_state("async_rst", 3'd0, 1'b0);
    @(negedge clk);
    check_state("rst_hold", 3'd0, 1'b0);

`ifdef PED_CROSS_EN
    sa = 1'b0; sb = 1'b0; ped = 1'b0;
    do_reset();
    repeat (2) @(negedge clk);
    ped = 1'b1;                                   // c2
    @(negedge clk);
    ped = 1'b0;
    check_state("ped c3", 3'd0, 1'b1);
    repeat (2) @(negedge clk);
    check_state("ped c5", 3'd0, 1'b1);
    @(negedge clk);
    check_state("ped c6", 3'd1, 1'b1);
    repeat (2) @(negedge clk);
    check_state("ped c8", 3'd2, 1'b1);
    ped = 1'b1;                                   // absorbed by the walk entry
    @(negedge clk);
    ped = 1'b0;
    check_state("ped c9", 3'd6, 1'b0);
    repeat (3) @(negedge clk);
    check_state("ped c12", 3'd6, 1'b0);
    @(negedge clk);
    check_state("ped c13", 3'd3, 1'b0);
`else
    sa = 1'b0; sb = 1'b0; ped = 1'b1;
    do_reset();
    repeat (30) @(negedge clk);
    check_state("ped ignored", 3'd0, 1'b0);
    ped = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
